// File: rtl/seq_det_pkg.sv
// Shared constants and fill-state encodings for the serial pattern detector.
package seq_det_pkg;

    localparam int SEQ_DET_DEF_LEN = 4;
    localparam logic [SEQ_DET_DEF_LEN-1:0] SEQ_DET_DEF_PATTERN = 4'b1001;

    localparam int SEQ_DET_N_MIN  = 2;
    localparam int SEQ_DET_N_MAX  = 16;
    localparam int SEQ_DET_CW_MIN = 1;
    localparam int SEQ_DET_CW_MAX = 16;

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_e;

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and fill tracking; exports the post-shift window
// and whether that window would hold N valid bits.
module seq_det_hist
    import seq_det_pkg::*;
#(
    parameter int N = SEQ_DET_DEF_LEN
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    input  logic         w,
    input  logic         restart,
    output logic [N-1:0] window,
    output logic         armed
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [N-1:0]  hist;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_adv;
    fill_state_e   state;

    // NOTE: every output of an always_comb gets a value on every path, so no latches.
    always_comb begin
        state    = (fill == FULL) ? ARMED : FILLING;
        fill_adv = (state == ARMED) ? FULL : fill + 1'b1;
        window   = {hist[N-2:0], w};
        armed    = (fill_adv == FULL);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window;
            // A non-overlapping match discards the window; hist keeps shifting regardless.
            fill <= restart ? '0 : fill_adv;
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Parametrised serial pattern detector with registered one-cycle match pulse.
// Define SEQDET_COUNT_EN to add the saturating match_count output.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int           N       = SEQ_DET_DEF_LEN,
    parameter logic [N-1:0] PATTERN = N'(SEQ_DET_DEF_PATTERN),
    parameter bit           OVERLAP = 1'b1,
    parameter int           CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic          w,
`ifdef SEQDET_COUNT_EN
    output logic [CW-1:0] match_count,
`endif
    output logic          z
);

    localparam bit PARAMS_OK = (N >= SEQ_DET_N_MIN) && (N <= SEQ_DET_N_MAX) &&
                               (CW >= SEQ_DET_CW_MIN) && (CW <= SEQ_DET_CW_MAX);

    // Legal range: N in 2..16, CW in 1..16; no logic depends on this block.
    if (!PARAMS_OK) begin : g_param_range_violation
    end

    logic [N-1:0] window;
    logic         armed;
    logic         match;
    logic         restart;

    always_comb begin
        match   = en && !clear && armed && (window == PATTERN);
        restart = match && (OVERLAP == 1'b0);
    end

    seq_det_hist #(
        .N(N)
    ) u_hist (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .clear  (clear),
        .w      (w),
        .restart(restart),
        .window (window),
        .armed  (armed)
    );

    // match already folds in en and clear, so stalls and clears force z low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z <= 1'b0;
        end else begin
            z <= match;
        end
    end

`ifdef SEQDET_COUNT_EN
    localparam logic [CW-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (clear) begin
            match_count <= '0;
        end else if (match && (match_count != CNT_MAX)) begin
            match_count <= match_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench: three detector configurations share one stimulus stream
// and are compared against a queue-based model of the detection rules.
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic clear;
    logic w;
    logic z_a, z_b, z_c;
`ifdef SEQDET_COUNT_EN
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: bits sampled since the last reset/clear/non-overlap match.
    bit q0[$];
    bit q1[$];
    bit q2[$];
    bit ez0, ez1, ez2;
    int c0, c1, c2;

    always #5 clk = ~clk;

    seq_pattern_detector #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CW(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .w(w),
`ifdef SEQDET_COUNT_EN
        .match_count(cnt_a),
`endif
        .z(z_a)
    );

    seq_pattern_detector #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CW(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .w(w),
`ifdef SEQDET_COUNT_EN
        .match_count(cnt_b),
`endif
        .z(z_b)
    );

    seq_pattern_detector #(.N(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CW(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .w(w),
`ifdef SEQDET_COUNT_EN
        .match_count(cnt_c),
`endif
        .z(z_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit ends_with(input bit s[$], input int n, input logic [15:0] pat);
        if (s.size() < n) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (s[s.size() - n + i] != pat[n-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete();
        ez0 = 0; ez1 = 0; ez2 = 0;
        c0 = 0; c1 = 0; c2 = 0;
    endtask

    task automatic model_edge();
        if (clear) begin
            model_reset();
        end else if (en) begin
            q0.push_back(w);
            ez0 = ends_with(q0, 4, 16'h0009);
            if (ez0 && c0 < 255) c0++;
            if (q0.size() > 16) q0.delete(0);

            q1.push_back(w);
            ez1 = ends_with(q1, 4, 16'h0009);
            if (ez1) begin
                if (c1 < 255) c1++;
                q1.delete();
            end
            if (q1.size() > 16) q1.delete(0);

            q2.push_back(w);
            ez2 = ends_with(q2, 3, 16'h0007);
            if (ez2 && c2 < 3) c2++;
            if (q2.size() > 16) q2.delete(0);
        end else begin
            ez0 = 0; ez1 = 0; ez2 = 0;
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, ".z_ovl"}, {31'd0, z_a}, {31'd0, ez0});
        check({phase, ".z_novl"}, {31'd0, z_b}, {31'd0, ez1});
        check({phase, ".z_111"}, {31'd0, z_c}, {31'd0, ez2});
`ifdef SEQDET_COUNT_EN
        check({phase, ".cnt_ovl"}, {24'd0, cnt_a}, c0);
        check({phase, ".cnt_novl"}, {24'd0, cnt_b}, c1);
        check({phase, ".cnt_111"}, {30'd0, cnt_c}, c2);
`endif
    endtask

    // One clock: drive on the falling edge, model the rising edge, sample 1 ns later.
    task automatic step(input string phase, input bit e, input bit c, input bit b);
        @(negedge clk);
        en = e; clear = c; w = b;
        @(posedge clk);
        model_edge();
        #1;
        check_all(phase);
    endtask

    task automatic feed(input string phase, input logic [15:0] bits, input int len);
        for (int i = len - 1; i >= 0; i--) step(phase, 1'b1, 1'b0, bits[i]);
    endtask

    task automatic async_reset_pulse(input string phase);
        @(negedge clk);
        #1 reset = 1'b1;
        model_reset();
        #1 check_all({phase, ".in_reset"});
        #1 reset = 1'b0;
    endtask

    initial begin
        en = 0; clear = 0; w = 0;
        reset = 1'b0;
        model_reset();
        #1 reset = 1'b1;
        #1 check_all("reset");
        #15 reset = 1'b0;

        // 0,0,1,0,0,1,1,0,0,1: pulses after samples 6 and 10
        feed("stream1", 16'b0010011001, 10);

        step("clr", 1'b0, 1'b1, 1'b0);
        // 1,0,0,1,0,0,1: overlap pulses at 4 and 7, non-overlap only at 4
        feed("stream2", 16'b1001001, 7);

        step("clr", 1'b0, 1'b1, 1'b0);
        feed("stall", 16'b100, 3);
        step("stall", 1'b0, 1'b0, 1'b1);
        step("stall", 1'b0, 1'b0, 1'b1);
        step("stall", 1'b1, 1'b0, 1'b1);

        step("clr", 1'b0, 1'b1, 1'b0);
        feed("rst_mid", 16'b100, 3);
        async_reset_pulse("rst_mid");
        feed("rst_mid", 16'b1, 1);
        feed("rst_mid", 16'b1001, 4);

        step("clr", 1'b0, 1'b1, 1'b0);
        feed("ones", 16'b111111, 6);

        step("clr", 1'b0, 1'b1, 1'b0);
        feed("clr_hit", 16'b100, 3);
        step("clr_hit", 1'b1, 1'b1, 1'b1);
        feed("clr_hit", 16'b1001, 4);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset_pulse("rand");
            end
            step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                 1'($urandom_range(0, 1)));
        end

        // Long run of ones to drive every counter into saturation.
        feed("sat", 16'hffff, 16);
        for (int i = 0; i < 300; i++) step("sat", 1'b1, 1'b0, 1'b1);
        feed("sat_tail", 16'b1001, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector: the next generation of the fixed 1001 detector. Samples one serial bit per enabled clock, compares the last N bits against a configurable pattern, and emits a one-cycle match pulse. Supports overlapping or non-overlapping detection and an optional saturating match counter. Sits directly on a serial input line in front of control logic that reacts to framing or marker sequences.

## Interface
- N, default 4: pattern length in bits, 2..16.
- PATTERN, default 4'b1001: N-bit pattern. The MSB is the oldest bit, so the MSB is compared first in time.
- OVERLAP, default 1: 1 lets a match reuse trailing bits of the previous match; 0 restarts after each match.
- CW, default 8: match counter width, 1..16.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- en  in  1: sample enable. w is consumed only on edges where en=1.
- clear  in  1: synchronous clear of detection state and counter.
- w  in  1: serial data bit.
- z  out  1: registered match pulse.
- match_count  out  CW: saturating number of matches. Present only with SEQDET_COUNT_EN.

## Operation
- State: history register hist[N-1:0] and fill counter fill ∈ 0..N. fill counts valid bits since reset, clear, or a non-overlap match.
- Fill states:
  - FILLING: fill<N. Each enabled edge increments fill.
  - ARMED: fill==N. fill holds at N.
- On each edge with en=1 and clear=0:
  - hist ← {hist[N-2:0], w}.
  - fill advances as described above.
  - Match condition: the post-shift {hist[N-2:0], w}==PATTERN and post-shift fill==N.
- On a match:
  - z←1.
  - If OVERLAP=0, fill←0. hist still shifts, but is ignored until refilled.
  - If OVERLAP=1, fill stays at N.
- On an edge with en=0: hist, fill and the counter hold; z←0.
- clear=1, which has priority over en: fill←0, hist←0, z←0, count←0.
- Counter: increments by 1 on each match and saturates at 2^CW−1, with no wrap.
- A match and clear in the same cycle: clear wins; no pulse, count=0.

## Timing
- Reset values: z=0, match_count=0, hist=0, fill=0.
- Latency: z goes high on the same rising edge that samples the final pattern bit. It stays high exactly one cycle unless the next enabled edge is also a match.
  - With OVERLAP=1, back-to-back z is possible (e.g. PATTERN=11, input 111).
  - With OVERLAP=0, consecutive z pulses are at least N enabled samples apart.
- match_count updates on the same edge as z.
- Reset asserted mid-sequence clears all partial progress immediately and asynchronously. After release, N fresh enabled samples are needed before any match.
- Reset release is synchronised externally. No input is sampled while reset=1.

## Configuration
- SEQDET_COUNT_EN defined: the match_count port and the CW-bit saturating counter are present.
- SEQDET_COUNT_EN undefined: no match_count port and no counter flops. The CW parameter is accepted but unused. z behaviour is identical in both builds.

## Structure
- Shared package seq_det_pkg holds:
  - Default pattern constant SEQ_DET_DEF_PATTERN=4'b1001 and default length 4.
  - Count-width limit constants.
  - Fill-state encodings FILLING and ARMED.
- One sub-module, seq_det_hist, contains hist, fill, en/clear handling and the fill-state logic. It exports the post-shift window and an armed flag.
- The top level holds the compare, the z register and the optional counter.

## Test plan
- Default parameters, OVERLAP=1. Reset 1.5 cycles, then w=0,0,1,0,0,1,1,0,0,1 with en=1 → z pulses after the 6th and 10th samples (1001 completes at samples 3–6 and 7–10); count=2.
- Stream 1,0,0,1,0,0,1, OVERLAP=1 → z after the 4th and 7th samples. Same stream with OVERLAP=0 → z only after the 4th sample.
- Stream 1,0,0 with en=1, then two cycles with en=0 carrying w=1, then en=1 with w=1 → exactly one z, on the final enabled edge; no z during stalls.
- Stream 1,0,0, then async reset pulse, then w=1 → no z. A full 1,0,0,1 after the reset → one z.
- N=3, PATTERN=3'b111, OVERLAP=1, CW=2, stream 1×6 → z high on samples 3–6 (4 pulses); match_count saturates at 3.
- clear asserted on the edge that would complete 1001 → z=0 and count=0. A following 1,0,0,1 → one z.
